permutation_engine: RTL

Iterative ASCON permutation core that executes one full round per clock: constant addition, then the 64-column S-box substitution layer, then linear diffusion. It holds the 320-bit state in a register. It runs either p12 (initialisation and finalisation) or p6 (data processing) under a start/done handshake. It sits between the ASCON-128 mode FSM, which loads and XORs the state, and the `substitution_layer` instance it feeds each round.

---
 rtl/permutation_engine.sv | 127 ++++++++++++
 1 files changed

// File: rtl/permutation_engine.sv
// ASCON permutation core: one round (constant add, S-box layer, linear diffusion)
// per clock, running p12 or p6 on a registered 320-bit state under start/done.
package permutation_engine_pkg;
  typedef logic [4:0][63:0] type_state;
endpackage

module substitution_layer
  import permutation_engine_pkg::*;
(
  input  type_state state,
  output type_state result
);
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic [4:0] col;
  logic [4:0] sub;

  // Column i gathers bit i of every lane, x0 as the S-box MSB.
  always_comb begin
    result = '0;
    col    = '0;
    sub    = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      col          = {state[0][i], state[1][i], state[2][i], state[3][i], state[4][i]};
      sub          = SBOX[col];
      result[0][i] = sub[4];
      result[1][i] = sub[3];
      result[2][i] = sub[2];
      result[3][i] = sub[1];
      result[4][i] = sub[0];
    end
  end
endmodule

module permutation_engine
  import permutation_engine_pkg::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] round_o
);
  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t       fsm, fsm_next;
  type_state  state_q, added, subbed, diffused;
  logic [3:0] round_q;
  logic       done_q;
  logic       last_round;

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  assign last_round = (round_q == 4'd11);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) fsm <= IDLE;
    else           fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (start_i) fsm_next = RUN;
      RUN:     if (last_round) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (fsm == RUN);
  end

  always_comb begin
    added          = state_q;
    added[2][7:0]  = state_q[2][7:0] ^ {4'd15 - round_q, round_q};
  end

  substitution_layer u_sbox (
    .state  (added),
    .result (subbed)
  );

  assign diffused[0] = subbed[0] ^ ror(subbed[0], 19) ^ ror(subbed[0], 28);
  assign diffused[1] = subbed[1] ^ ror(subbed[1], 61) ^ ror(subbed[1], 39);
  assign diffused[2] = subbed[2] ^ ror(subbed[2], 1)  ^ ror(subbed[2], 6);
  assign diffused[3] = subbed[3] ^ ror(subbed[3], 10) ^ ror(subbed[3], 17);
  assign diffused[4] = subbed[4] ^ ror(subbed[4], 7)  ^ ror(subbed[4], 41);

  // The counter is left at 12 after the final round so round_o reads 12 until the next start.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm)
        IDLE: if (start_i) begin
          state_q <= state_i;
          round_q <= mode_i ? 4'd6 : 4'd0;
        end
        RUN: begin
          state_q <= diffused;
          round_q <= round_q + 4'd1;
          done_q  <= last_round;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;
  assign done_o  = done_q;
  assign round_o = round_q;
endmodule
